// File: rtl/bcd_display_scan_pkg.sv
// rtl/bcd_display_scan_pkg.sv - shared segment patterns, digit-index type and anode constants
package bcd_disp_pkg;

    typedef enum logic [1:0] {
        ONES     = 2'd0,
        TENS     = 2'd1,
        HUNDREDS = 2'd2
    } digit_e;

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0   = 7'b1000000;
    localparam logic [6:0] SEG_1   = 7'b1111001;
    localparam logic [6:0] SEG_2   = 7'b0100100;
    localparam logic [6:0] SEG_3   = 7'b0110000;
    localparam logic [6:0] SEG_4   = 7'b0011001;
    localparam logic [6:0] SEG_5   = 7'b0010010;
    localparam logic [6:0] SEG_6   = 7'b0000010;
    localparam logic [6:0] SEG_7   = 7'b1111000;
    localparam logic [6:0] SEG_8   = 7'b0000000;
    localparam logic [6:0] SEG_9   = 7'b0010000;
    localparam logic [6:0] DASH    = 7'b0111111;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam logic [2:0] AN_OFF      = 3'b111;
    localparam logic [2:0] AN_ONES     = 3'b110;
    localparam logic [2:0] AN_TENS     = 3'b101;
    localparam logic [2:0] AN_HUNDREDS = 3'b011;

endpackage

// File: rtl/bcd_display_scan_if.sv
// rtl/bcd_display_scan_if.sv - digit load and display drive signals of the scan driver
interface bcd_display_scan_if;
    logic       load;
    logic [3:0] ones;
    logic [3:0] tens;
    logic [1:0] hundreds;
    logic       blank_lz;
    logic [6:0] seg;
    logic [2:0] an;
    logic       frame_done;

    modport master (
        output load, ones, tens, hundreds, blank_lz,
        input  seg, an, frame_done
    );

    modport slave (
        input  load, ones, tens, hundreds, blank_lz,
        output seg, an, frame_done
    );
endinterface

// File: rtl/bcd_to_seg.sv
// rtl/bcd_to_seg.sv - combinational BCD to active-low seven-segment decoder, dash on invalid
module bcd_to_seg
    import bcd_disp_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);
    always_comb begin
        seg = DASH;
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = DASH;
        endcase
    end
endmodule

// File: rtl/bcd_display_scan.sv
// rtl/bcd_display_scan.sv - double-buffered three-digit multiplexed seven-segment scanner
module bcd_display_scan
    import bcd_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 500
) (
    input  logic               clk,
    input  logic               rst_n,
    bcd_display_scan_if.slave  disp
);
    localparam int CW = $clog2(REFRESH_DIV);

    if (!(REFRESH_DIV > BLANK_CYC && BLANK_CYC >= 1)) begin : g_bad_params
        $error("bcd_display_scan: need REFRESH_DIV > BLANK_CYC >= 1");
    end

    digit_e          d_q, d_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [9:0]      shadow_q, active_q;
    logic [9:0]      digits_in;
    logic            wrap, boundary;
    logic [3:0]      digit_sel;
    logic [6:0]      dec_seg;
    logic [6:0]      seg_d;
    logic [2:0]      an_d;
    logic            fd_d;
    logic            blank_digit;

    assign digits_in = {disp.hundreds, disp.tens, disp.ones};
    assign wrap      = (cnt_q == CW'(REFRESH_DIV - 1));
    assign boundary  = wrap && (d_q == HUNDREDS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            d_q   <= ONES;
        end else begin
            cnt_q <= cnt_d;
            d_q   <= d_d;
        end
    end

    always_comb begin
        cnt_d = wrap ? '0 : cnt_q + CW'(1);
        d_d   = d_q;
        if (wrap) begin
            case (d_q)
                ONES:     d_d = TENS;
                TENS:     d_d = HUNDREDS;
                HUNDREDS: d_d = ONES;
                default:  d_d = ONES;
            endcase
        end
    end

    // A load on the boundary cycle bypasses the shadow so it is shown in the coming frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
            active_q <= '0;
        end else begin
            if (disp.load)
                shadow_q <= digits_in;
            if (boundary)
                active_q <= disp.load ? digits_in : shadow_q;
        end
    end

    always_comb begin
        digit_sel = active_q[3:0];
        case (d_q)
            TENS:     digit_sel = active_q[7:4];
            HUNDREDS: digit_sel = {2'b00, active_q[9:8]};
            default:  digit_sel = active_q[3:0];
        endcase
    end

    bcd_to_seg u_dec (
        .bcd (digit_sel),
        .seg (dec_seg)
    );

    always_comb begin
        seg_d       = SEG_OFF;
        an_d        = AN_OFF;
        blank_digit = 1'b0;
        fd_d        = boundary;
        if (cnt_q >= CW'(BLANK_CYC)) begin
            case (d_q)
                TENS: begin
                    an_d        = AN_TENS;
                    blank_digit = disp.blank_lz && (active_q[9:8] == 2'd0)
                                  && (active_q[7:4] == 4'd0);
                end
                HUNDREDS: begin
                    an_d        = AN_HUNDREDS;
                    blank_digit = disp.blank_lz && (active_q[9:8] == 2'd0);
                end
                default: an_d = AN_ONES;
            endcase
            seg_d = blank_digit ? SEG_OFF : dec_seg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp.seg        <= SEG_OFF;
            disp.an         <= AN_OFF;
            disp.frame_done <= 1'b0;
        end else begin
            disp.seg        <= seg_d;
            disp.an         <= an_d;
            disp.frame_done <= fd_d;
        end
    end
endmodule

// File: tb/tb_bcd_display_scan.sv
// tb/tb_bcd_display_scan.sv - scoreboard bench for bcd_display_scan against a positional frame model
module tb_bcd_display_scan;
    localparam int RD    = 8;
    localparam int BC    = 2;
    localparam int FRAME = 3 * RD;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    bcd_display_scan_if ifc();

    bcd_display_scan #(.REFRESH_DIV(RD), .BLANK_CYC(BC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .disp  (ifc)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected {frame_done, an, seg} per output update
    logic [10:0] exp_q[$];
    int          p        = 0;
    logic [9:0]  m_shadow = '0;
    logic [9:0]  m_active = '0;

    function automatic logic [6:0] ref_seg(input logic [3:0] v);
        case (v)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    // Position pos counts cycles since reset release; slot and offset follow by division.
    function automatic logic [10:0] ref_out(input int pos, input logic [9:0] act, input logic blz);
        int         slot;
        int         off;
        logic       fd;
        logic [3:0] h;
        logic [3:0] t;
        logic [3:0] o;
        slot = (pos / RD) % 3;
        off  = pos % RD;
        fd   = (slot == 2) && (off == RD - 1);
        h    = {2'b00, act[9:8]};
        t    = act[7:4];
        o    = act[3:0];
        if (off < BC)
            return {fd, 3'b111, 7'h7F};
        case (slot)
            0:       return {fd, 3'b110, ref_seg(o)};
            1:       return {fd, 3'b101, (blz && h == 0 && t == 0) ? 7'h7F : ref_seg(t)};
            default: return {fd, 3'b011, (blz && h == 0) ? 7'h7F : ref_seg(h)};
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p        = 0;
            m_shadow = '0;
            m_active = '0;
            exp_q.delete();
        end else begin
            exp_q.push_back(ref_out(p, m_active, ifc.blank_lz));
            if (p % FRAME == FRAME - 1)
                m_active = ifc.load ? {ifc.hundreds, ifc.tens, ifc.ones} : m_shadow;
            if (ifc.load)
                m_shadow = {ifc.hundreds, ifc.tens, ifc.ones};
            p++;
        end
    end

    always @(negedge clk) begin
        logic [10:0] e;
        logic [10:0] a;
        a = {ifc.frame_done, ifc.an, ifc.seg};
        if (!rst_n || exp_q.size() == 0)
            e = {1'b0, 3'b111, 7'h7F};
        else
            e = exp_q.pop_front();
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL scan t=%0t: got fd=%b an=%b seg=%b, want fd=%b an=%b seg=%b",
                     $time, a[10], a[9:7], a[6:0], e[10], e[9:7], e[6:0]);
        end
        n_cmp++;
        if (!(a[9:7] inside {3'b111, 3'b110, 3'b101, 3'b011})) begin
            n_bad++;
            $display("FAIL an_legal t=%0t: got an=%b, want one-hot-low or 111", $time, a[9:7]);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_val(input logic [1:0] h, input logic [3:0] t, input logic [3:0] o);
        ifc.hundreds = h;
        ifc.tens     = t;
        ifc.ones     = o;
        ifc.load     = 1'b1;
        tick(1);
        ifc.load     = 1'b0;
    endtask

    task automatic wait_pos(input int target);
        int k = 0;
        while ((p % FRAME) != target && k < 4 * FRAME) begin
            tick(1);
            k++;
        end
        n_cmp++;
        if ((p % FRAME) != target) begin
            n_bad++;
            $display("FAIL wait_pos: got position %0d, want %0d", p % FRAME, target);
        end
    endtask

    initial begin
        ifc.load     = 1'b0;
        ifc.ones     = '0;
        ifc.tens     = '0;
        ifc.hundreds = '0;
        ifc.blank_lz = 1'b0;
        rst_n        = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b1;
        tick(30);

        load_val(2'd2, 4'd5, 4'd5);
        tick(2 * FRAME);

        ifc.blank_lz = 1'b1;
        load_val(2'd0, 4'd0, 4'd7);
        tick(2 * FRAME);
        ifc.blank_lz = 1'b0;
        tick(FRAME);

        wait_pos(5);
        load_val(2'd1, 4'd2, 4'd3);
        tick(2 * FRAME);

        wait_pos(FRAME - 1);
        load_val(2'd0, 4'd4, 4'd8);
        tick(FRAME);

        load_val(2'd0, 4'hC, 4'd1);
        tick(2 * FRAME);

        wait_pos(RD + BC + 1);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({ifc.frame_done, ifc.an, ifc.seg} !== {1'b0, 3'b111, 7'h7F}) begin
            n_bad++;
            $display("FAIL async_reset: got fd=%b an=%b seg=%b, want fd=0 an=111 seg=1111111",
                     ifc.frame_done, ifc.an, ifc.seg);
        end
        tick(2);
        rst_n = 1'b1;
        tick(FRAME + 4);

        repeat (60) begin
            if ($urandom_range(0, 3) == 0)
                ifc.blank_lz = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0)
                load_val(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                         4'($urandom_range(0, 15)));
            else
                tick($urandom_range(1, 10));
        end
        tick(2 * FRAME);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/bcd_display_scan.md
# bcd_display_scan

Time-multiplexed three-digit seven-segment driver that sits directly downstream of the binary-to-BCD converter. It captures the ONES/TENS/HUNDREDS digit outputs on a load strobe and double-buffers them so a frame never tears. It then scans the digits onto a common-anode display with a per-digit anti-ghosting blank interval. It also provides optional leading-zero blanking and a frame-complete pulse.

## Interface
- REFRESH_DIV, 50000, clock cycles per digit slot; must be greater than BLANK_CYC.
- BLANK_CYC, 500, cycles at the start of each slot with all anodes off; must be at least 1.
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- load  input  1  capture strobe for the digit inputs, sampled every cycle.
- ones  input  4  BCD units digit.
- tens  input  4  BCD tens digit.
- hundreds  input  2  BCD hundreds digit, range 0–2 as produced upstream.
- blank_lz  input  1  enable leading-zero blanking; level-sensitive, sampled every cycle.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- an  output  3  anodes {hundreds,tens,ones}, active-low, one-hot-low or all-high.
- frame_done  output  1  single-cycle pulse at the end of the hundreds slot.

## Operation
- Shadow register:
  - On any cycle with load=1, capture {hundreds,tens,ones} into the shadow register.
  - Repeated loads overwrite; the last one before the frame boundary wins.
- Active register:
  - Copies the shadow register on the frame-boundary cycle, i.e. the cycle the slot counter wraps into the ones slot.
  - If load=1 on that same cycle, active takes the input values directly (bypass), not the stale shadow.
- State machine, digit index D ∈ {ONES, TENS, HUNDREDS}, visited in that order:
  - Each state has two phases, BLANK then ON.
  - Slot counter runs 0..REFRESH_DIV-1 and wraps.
  - BLANK phase: counter < BLANK_CYC. an=3'b111, seg=7'h7F.
  - ON phase: counter ≥ BLANK_CYC. The selected anode is low and seg carries the decoded digit.
  - On wrap, D advances: ONES→TENS→HUNDREDS→ONES.
- Decode, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Any value above 9 shows a dash, 0111111.
  - hundreds is zero-extended to 4 bits before decode.
- Leading-zero blanking, blank_lz=1:
  - HUNDREDS slot shows seg=7'h7F when active hundreds=0.
  - TENS slot shows 7'h7F when active hundreds=0 and tens=0.
  - ONES is never blanked, so a value of 0 displays "0".
  - The anode still asserts during a blanked digit, keeping slot timing uniform.
- frame_done: asserted on the final cycle of the HUNDREDS slot (counter=REFRESH_DIV-1, D=HUNDREDS).

## Timing
- Reset values:
  - seg=7'h7F, an=3'b111, frame_done=0.
  - Counter=0, D=ONES, shadow=0, active=0.
- seg, an and frame_done are registered.
  - They reflect the counter/D state of the previous cycle, one cycle of latency.
  - seg and an always change on the same edge.
- First lit output after reset release: the ONES anode goes low at edge BLANK_CYC+1 after the first clock following deassertion.
- Frame length is 3·REFRESH_DIV cycles.
- Load-to-display latency depends on the load cycle:
  - Load on the frame-boundary cycle: visible in that frame.
  - Any other load: visible from the next frame boundary.
- Asynchronous reset mid-frame returns immediately to the reset values. Shadow and active are cleared; any pending load is lost.
- blank_lz changes take effect on the next registered output update, with no frame alignment.

## Structure
- Shared package bcd_disp_pkg holds:
  - the segment-pattern constants, digits 0–9, DASH and SEG_OFF;
  - the digit-index state type {ONES, TENS, HUNDREDS};
  - AN_OFF=3'b111.
- One natural sub-module: bcd_to_seg, a combinational 4-bit BCD-to-active-low-segment decoder with dash on invalid input.
- Counter width is the ceiling of log2(REFRESH_DIV). An elaboration check enforces REFRESH_DIV > BLANK_CYC ≥ 1.

## Test plan
All scenarios use REFRESH_DIV=8 and BLANK_CYC=2.
- Reset behaviour: hold rst_n=0 for 5 cycles then release -> seg=7F, an=111 during reset; ones slot shows seg=1000000, an=110 from the 3rd post-reset output update.
- Basic scan: load 2/5/5 (hundreds/tens/ones) -> next frame shows an=110 with seg=0010010, an=101 with seg=0010010, an=011 with seg=0100100; each slot has 2 blank cycles with an=111; frame_done pulses once every 24 cycles.
- Leading-zero blanking: blank_lz=1, load 0/0/7 -> hundreds and tens slots show seg=7F with their anode low; ones slot shows 1111000.
- Same input with blank_lz=0 -> hundreds and tens slots show 1000000.
- Load timing: load 1/2/3 mid-frame -> current frame keeps its old digits and the new digits appear at the next ones slot. Load 0/4/8 exactly on the boundary cycle -> 0/4/8 appear in that frame.
- Invalid and reset mid-frame: load tens=4'hC -> tens slot shows 0111111. Assert rst_n=0 during the tens ON phase -> an=111 and seg=7F immediately, and the display restarts at the ones slot showing 0.
